board_renderer: RTL and testbench

- Sequential drawing engine that paints the 3x3 tic-tac-toe board onto the 160x120 VGA adapter.
- On `start`, it snapshots the 18-bit grid word and walks cells 0..8 in order.
- For each cell it emits one plot strobe per pixel of a CELL_SIZE x CELL_SIZE filled square, at the cell's fixed origin, in the colour of the cell's state.
- Sits between the game-state logic (grid producer) and the VGA adapter's plot/x/y/colour inputs.

---
 rtl/board_renderer_pkg.sv | 36 +++
 rtl/board_renderer_cell_origin_lut.sv | 60 ++++++
 rtl/board_renderer.sv | 122 ++++++++++++
 tb/tb_board_renderer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/board_renderer_pkg.sv
// Shared constants for the tic-tac-toe board renderer: cell codes, colours,
// cell origin tables and the drawing FSM encoding.
package board_renderer_pkg;

  localparam logic [1:0] CODE_EMPTY = 2'd0;
  localparam logic [1:0] CODE_O     = 2'd1;
  localparam logic [1:0] CODE_X     = 2'd2;

  localparam logic [2:0] DEF_COL_EMPTY = 3'b111;
  localparam logic [2:0] DEF_COL_O     = 3'b011;
  localparam logic [2:0] DEF_COL_X     = 3'b101;
  // Illegal cell code paints black so a corrupted grid is visible on screen
  localparam logic [2:0] COL_FAULT     = 3'b000;

  localparam logic [7:0] ORG_X0 = 8'd37;
  localparam logic [7:0] ORG_X1 = 8'd67;
  localparam logic [7:0] ORG_X2 = 8'd97;
  localparam logic [6:0] ORG_Y0 = 7'd7;
  localparam logic [6:0] ORG_Y1 = 7'd37;
  localparam logic [6:0] ORG_Y2 = 7'd67;

  localparam logic [3:0] LAST_CELL = 4'd8;

  // state     | meaning
  // ST_IDLE   | waiting for start, grid snapshot taken on accept
  // ST_LOAD   | clear cell/pixel counters
  // ST_DRAW   | one plot strobe per cycle, cells 0..8 back to back
  // ST_FINISH | drop busy, pulse done
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/board_renderer_cell_origin_lut.sv
// Maps a cell index and the grid snapshot to that cell's screen origin and
// fill colour. Purely combinational.
module cell_origin_lut
  import board_renderer_pkg::*;
#(
  parameter logic [2:0] COL_EMPTY = DEF_COL_EMPTY,
  parameter logic [2:0] COL_O     = DEF_COL_O,
  parameter logic [2:0] COL_X     = DEF_COL_X
) (
  input  logic [3:0]  i_cell,
  input  logic [17:0] i_snap,
  output logic [7:0]  o_ox,
  output logic [6:0]  o_oy,
  output logic [2:0]  o_colour
);

  logic [1:0] w_col;
  logic [1:0] w_row;
  logic [1:0] w_code;

  // Split the row-major cell index into column/row and pick its 2-bit code
  always_comb begin
    w_col  = 2'd0;
    w_row  = 2'd0;
    w_code = i_snap[17:16];
    case (i_cell)
      4'd0: begin w_col = 2'd0; w_row = 2'd0; w_code = i_snap[17:16]; end
      4'd1: begin w_col = 2'd1; w_row = 2'd0; w_code = i_snap[15:14]; end
      4'd2: begin w_col = 2'd2; w_row = 2'd0; w_code = i_snap[13:12]; end
      4'd3: begin w_col = 2'd0; w_row = 2'd1; w_code = i_snap[11:10]; end
      4'd4: begin w_col = 2'd1; w_row = 2'd1; w_code = i_snap[9:8];   end
      4'd5: begin w_col = 2'd2; w_row = 2'd1; w_code = i_snap[7:6];   end
      4'd6: begin w_col = 2'd0; w_row = 2'd2; w_code = i_snap[5:4];   end
      4'd7: begin w_col = 2'd1; w_row = 2'd2; w_code = i_snap[3:2];   end
      4'd8: begin w_col = 2'd2; w_row = 2'd2; w_code = i_snap[1:0];   end
      default: begin w_col = 2'd0; w_row = 2'd0; w_code = i_snap[17:16]; end
    endcase
  end

  // Origin tables and colour map
  always_comb begin
    case (w_col)
      2'd1:    o_ox = ORG_X1;
      2'd2:    o_ox = ORG_X2;
      default: o_ox = ORG_X0;
    endcase
    case (w_row)
      2'd1:    o_oy = ORG_Y1;
      2'd2:    o_oy = ORG_Y2;
      default: o_oy = ORG_Y0;
    endcase
    case (w_code)
      CODE_EMPTY: o_colour = COL_EMPTY;
      CODE_O:     o_colour = COL_O;
      CODE_X:     o_colour = COL_X;
      default:    o_colour = COL_FAULT;
    endcase
  end

endmodule

// File: rtl/board_renderer.sv
// Paints the 3x3 board onto the VGA adapter: one plot strobe per pixel of a
// filled CELL_SIZE square per cell, cells 0..8 in row-major order.
module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int         CELL_SIZE = 20,
  parameter logic [2:0] COL_EMPTY = DEF_COL_EMPTY,
  parameter logic [2:0] COL_O     = DEF_COL_O,
  parameter logic [2:0] COL_X     = DEF_COL_X
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [17:0] grid,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_PX = 5'(CELL_SIZE - 1);

  state_t      r_state;
  logic [17:0] r_snap;
  logic [3:0]  r_cell;
  logic [4:0]  r_px;
  logic [4:0]  r_py;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_ox;
  logic [6:0]  w_oy;
  logic [2:0]  w_colour;

  cell_origin_lut #(
    .COL_EMPTY (COL_EMPTY),
    .COL_O     (COL_O),
    .COL_X     (COL_X)
  ) u_lut (
    .i_cell   (r_cell),
    .i_snap   (r_snap),
    .o_ox     (w_ox),
    .o_oy     (w_oy),
    .o_colour (w_colour)
  );

  // Drawing FSM with registered VGA outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_snap   <= '0;
      r_cell   <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          // a start coinciding with the done pulse is dropped; requester retries
          if (start && !r_done) begin
            r_snap  <= grid;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cell  <= '0;
          r_px    <= '0;
          r_py    <= '0;
          r_busy  <= 1'b1;
          r_state <= ST_DRAW;
        end
        ST_DRAW: begin
          r_x      <= w_ox + {3'b000, r_px};
          r_y      <= w_oy + {2'b00, r_py};
          r_colour <= w_colour;
          r_plot   <= 1'b1;
          if (r_px == LAST_PX) begin
            r_px <= '0;
            if (r_py == LAST_PX) begin
              r_py <= '0;
              if (r_cell == LAST_CELL) r_state <= ST_FINISH;
              else                     r_cell  <= r_cell + 4'd1;
            end else begin
              r_py <= r_py + 5'd1;
            end
          end else begin
            r_px <= r_px + 5'd1;
          end
        end
        ST_FINISH: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_board_renderer.sv
// Cycle-exact checks of board_renderer against a pixel-sequence model
// derived from cell origins, cell size and the colour map.
module tb_board_renderer;

  localparam int CS   = 20;
  localparam int NPIX = 9 * CS * CS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] grid = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  logic        s_start = 1'b0;
  logic [17:0] s_grid = '0;
  logic [7:0]  s_x;
  logic [6:0]  s_y;
  logic [2:0]  s_colour;
  logic        s_plot, s_busy, s_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  board_renderer #(.CELL_SIZE(CS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .grid(grid),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  board_renderer #(.CELL_SIZE(1)) dut_small (
    .clk(clk), .resetn(resetn), .start(s_start), .grid(s_grid),
    .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot), .busy(s_busy), .done(s_done)
  );

  // Pixel idx of a draw: cell k = idx / cs^2, scanned px fastest then py.
  function automatic void model_pixel(input logic [17:0] g, input int idx, input int cs,
                                      output int ex, output int ey, output int ec);
    int k, r, code;
    k    = idx / (cs * cs);
    r    = idx % (cs * cs);
    ex   = 37 + 30 * (k % 3) + r % cs;
    ey   = 7 + 30 * (k / 3) + r / cs;
    code = int'((g >> (16 - 2 * k)) & 18'h3);
    case (code)
      0:       ec = 7;
      1:       ec = 3;
      2:       ec = 5;
      default: ec = 0;
    endcase
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({x, y, colour, plot, busy, done, s_plot, s_busy, s_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got x=%0d y=%0d col=%0d plot=%b busy=%b done=%b, want all 0",
               x, y, colour, plot, busy, done);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
  endtask

  // Full draw, checked every cycle. Optionally corrupts grid and re-pulses
  // start mid-draw, or pulses start during the done cycle.
  task automatic run_draw(input string name, input logic [17:0] g,
                          input bit mid_change, input bit start_in_done);
    int ex, ey, ec, lx, ly, lc;
    logic ep, eb, ed;
    bit chk;
    model_pixel(g, NPIX - 1, CS, lx, ly, lc);
    grid = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept: got busy=%b plot=%b, want busy=1 plot=0", name, busy, plot);
    end
    for (int c = 1; c <= NPIX + 2; c++) begin
      if (mid_change && c == 100) grid = 18'h2AAAA;
      start = (mid_change && c == 200);
      @(posedge clk); #1;
      start = 1'b0;
      ex = 0; ey = 0; ec = 0; chk = 1'b1;
      if (c == 1) begin
        ep = 0; eb = 1; ed = 0; chk = 1'b0;
      end else if (c <= NPIX + 1) begin
        ep = 1; eb = 1; ed = 0;
        model_pixel(g, c - 2, CS, ex, ey, ec);
      end else begin
        ep = 0; eb = 0; ed = 1; ex = lx; ey = ly; ec = lc;
      end
      vectors++;
      if (plot !== ep || busy !== eb || done !== ed ||
          (chk && (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(ec)))) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%0d, want plot=%b busy=%b done=%b x=%0d y=%0d col=%0d",
                 name, c, plot, busy, done, x, y, colour, ep, eb, ed, ex, ey, ec);
      end
    end
    start = start_in_done;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          x !== 8'(lx) || y !== 7'(ly) || colour !== 3'(lc)) begin
        miscompares++;
        $display("FAIL %s post %0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%0d, want 0 0 0 x=%0d y=%0d col=%0d",
                 name, c, plot, busy, done, x, y, colour, lx, ly, lc);
      end
    end
  endtask

  task automatic test_reset_mid();
    grid = 18'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    vectors++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got x=%0d y=%0d col=%0d plot=%b busy=%b done=%b, want all 0",
               x, y, colour, plot, busy, done);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet %0d: got plot=%b busy=%b done=%b, want 0 0 0",
                 c, plot, busy, done);
      end
    end
    run_draw("after_reset", 18'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_small();
    logic [17:0] g;
    int ex, ey, ec;
    logic ep, ed;
    g = 18'($urandom);
    s_grid = g; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      ep = (c >= 2 && c <= 10);
      ed = (c == 11);
      ex = 0; ey = 0; ec = 0;
      if (ep) model_pixel(g, c - 2, 1, ex, ey, ec);
      vectors++;
      if (s_plot !== ep || s_done !== ed ||
          (ep && (s_x !== 8'(ex) || s_y !== 7'(ey) || s_colour !== 3'(ec)))) begin
        miscompares++;
        $display("FAIL small cyc %0d: got plot=%b done=%b x=%0d y=%0d col=%0d, want plot=%b done=%b x=%0d y=%0d col=%0d",
                 c, s_plot, s_done, s_x, s_y, s_colour, ep, ed, ex, ey, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    run_draw("all_empty", 18'h00000, 1'b0, 1'b0);
    run_draw("o_and_x", 18'h10200, 1'b0, 1'b0);
    run_draw("illegal_cell8", 18'h00003, 1'b0, 1'b0);
    run_draw("snapshot", 18'($urandom), 1'b1, 1'b0);
    run_draw("start_at_done", 18'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) run_draw("random", 18'($urandom), 1'b0, 1'b0);
    test_reset_mid();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
